// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave byte-level blocks (read byte / write
// byte). Holds the byte width, the bit-counter width and the common byte
// state encoding so both directions stay in lock-step.
// -----------------------------------------------------------------------------
package i2c_pkg;

   localparam int BYTE_WIDTH = 8;
   localparam int BIT_CNT_W  = 4;

   // Counter value seen on the rising edge that carries the last bit.
   localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(BYTE_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } byte_state_t;

endpackage

// File: rtl/i2c_line_edge_detect.sv
// -----------------------------------------------------------------------------
// i2c_line_edge_detect
// Registers the (already synchronized) SCL/SDA levels once per clk and derives
// single-cycle edge strobes from the previous/current levels. The history
// flops run regardless of any enable so edges are valid the very first cycle a
// byte block is enabled.
//
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   scl_i/sda_i : current line levels
//   scl_rise    : SCL went 0 -> 1 this cycle
//   scl_fall    : SCL went 1 -> 0 this cycle
//   sda_chg     : SDA differs from its previous sample
// -----------------------------------------------------------------------------
module i2c_line_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_chg
);

   logic scl_last;
   logic sda_last;

   // Both lines idle high on the bus, so reset the history high too; this
   // avoids a spurious rise/change right after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_last <= 1'b1;
         sda_last <= 1'b1;
      end else begin
         scl_last <= scl_i;
         sda_last <= sda_i;
      end
   end

   assign scl_rise = ~scl_last &  scl_i;
   assign scl_fall =  scl_last & ~scl_i;
   assign sda_chg  =  sda_last ^  sda_i;

endmodule

// File: rtl/i2c_slave_read_byte.sv
// -----------------------------------------------------------------------------
// i2c_slave_read_byte
// Slave-side I2C byte receiver. While byte_read_en is high it shifts in eight
// SDA bits (MSB first) on SCL rising edges, then publishes the byte with a
// one-cycle finish pulse. An SDA change while SCL is held high (START/STOP-like
// condition) after at least one bit has been taken aborts the byte with a
// one-cycle error pulse.
//
// Ports:
//   clk, rst_n       : system clock, synchronous active-low reset
//   byte_read_en     : level enable from the slave controller; low = idle/abort
//   byte_read_o      : last completed byte, only updated on completion
//   byte_read_err    : 1-cycle pulse, SDA moved while SCL high mid-byte
//   byte_read_finish : 1-cycle pulse, byte_read_o holds a fresh byte
//   scl_i, sda_i     : synchronized bus levels
// -----------------------------------------------------------------------------
import i2c_pkg::*;

module i2c_slave_read_byte (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  byte_read_en,
   output logic [BYTE_WIDTH-1:0] byte_read_o,
   output logic                  byte_read_err,
   output logic                  byte_read_finish,
   input  logic                  scl_i,
   input  logic                  sda_i
);

   logic                  scl_rise;
   logic                  scl_fall;
   logic                  sda_chg;
   logic                  scl_hold_high;
   logic                  sda_violation;
   logic [BYTE_WIDTH-1:0] shift_q;
   logic [BYTE_WIDTH-1:0] shift_nxt;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   byte_state_t           state;

   i2c_line_edge_detect u_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .sda_chg  (sda_chg)
   );

   // SCL was high last cycle and still is: neither edge is in flight. SDA
   // must be stable inside this window; while SCL is low it may move freely.
   assign scl_hold_high = scl_i & ~scl_rise & ~scl_fall;

   // Only meaningful once a bit has actually been captured, so the edge where
   // the controller raises the enable during a START does not trip it.
   assign sda_violation = (bit_cnt != '0) & scl_hold_high & sda_chg;

   assign shift_nxt = {shift_q[BYTE_WIDTH-2:0], sda_i};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         bit_cnt          <= '0;
         shift_q          <= '0;
         byte_read_o      <= '0;
         byte_read_err    <= 1'b0;
         byte_read_finish <= 1'b0;
      end else begin
         // Pulses default low; any branch below raises at most one of them.
         byte_read_err    <= 1'b0;
         byte_read_finish <= 1'b0;

         case (state)
            IDLE: begin
               if (byte_read_en) begin
                  state <= RECV;
                  // A rise coinciding with the enable is the first data bit.
                  if (scl_rise) begin
                     shift_q <= shift_nxt;
                     bit_cnt <= BIT_CNT_W'(1);
                  end else begin
                     bit_cnt <= '0;
                  end
               end
            end

            RECV: begin
               if (!byte_read_en) begin
                  // Controller abort: drop the partial byte silently.
                  state   <= IDLE;
                  bit_cnt <= '0;
               end else if (sda_violation) begin
                  // Violation outranks a completing rise; byte_read_o keeps
                  // the last good byte.
                  byte_read_err <= 1'b1;
                  bit_cnt       <= '0;
                  state         <= IDLE;
               end else if (scl_rise) begin
                  shift_q <= shift_nxt;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_CNT_LAST) begin
                     byte_read_o      <= shift_nxt;
                     byte_read_finish <= 1'b1;
                     state            <= DONE;
                  end
               end
            end

            DONE: begin
               // Wait for the controller to release us; the bus is not
               // watched here (ACK phase belongs to the controller).
               if (!byte_read_en) begin
                  state   <= IDLE;
                  bit_cnt <= '0;
               end
            end

            default: begin
               state   <= IDLE;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_read_byte
// Directed I2C byte stimulus; expected pulses are queued with their data and
// the cycle they must appear in, and a monitor pops them as the DUT pulses.
// -----------------------------------------------------------------------------
module tb_i2c_slave_read_byte;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       byte_read_en;
   logic [7:0] byte_read_o;
   logic       byte_read_err;
   logic       byte_read_finish;
   logic       scl_i;
   logic       sda_i;

   int   cyc;
   int   n_checks;
   int   n_fail;
   logic [7:0] exp_byte;
   exp_t exp_q[$];

   i2c_slave_read_byte dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .byte_read_en     (byte_read_en),
      .byte_read_o      (byte_read_o),
      .byte_read_err    (byte_read_err),
      .byte_read_finish (byte_read_finish),
      .scl_i            (scl_i),
      .sda_i            (sda_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // A pulse raised by an input change at a negedge shows up right after the
   // following posedge, i.e. at cycle count cyc+1.
   task automatic push(input logic is_err, input logic [7:0] data);
      exp_t e;
      e.is_err = is_err;
      e.data   = data;
      e.cyc    = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Master side: SDA changes on SCL fall, enable raised at the first fall.
   task automatic send_byte(input logic [7:0] b, input int half, input bit drop);
      @(negedge clk);
      scl_i = 1'b0; byte_read_en = 1'b1; sda_i = b[7];
      wait_clks(half - 1);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         scl_i = 1'b1;
         if (i == 0) push(1'b0, b);
         wait_clks(half - 1);
         @(negedge clk);
         scl_i = 1'b0;
         if (i > 0) sda_i = b[i-1];
         wait_clks(half - 1);
      end
      if (drop) begin
         @(negedge clk);
         byte_read_en = 1'b0;
         wait_clks(1);
      end
   endtask

   // Monitor / scoreboard
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n) begin
         check("err_finish_exclusive", int'(byte_read_finish & byte_read_err), 0);
         if (byte_read_finish || byte_read_err) begin
            check("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("pulse_is_err", int'(byte_read_err), int'(e.is_err));
               check("pulse_cycle", cyc, e.cyc);
               check("pulse_byte", int'(byte_read_o), int'(e.data));
               if (!e.is_err) exp_byte = e.data;
            end
         end else begin
            check("byte_hold", int'(byte_read_o), int'(exp_byte));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_byte = 8'h00;
      rst_n = 1'b0; byte_read_en = 1'b0; scl_i = 1'b1; sda_i = 1'b1;

      // Reset values
      wait_clks(2);
      check("reset_byte", int'(byte_read_o), 0);
      check("reset_finish", int'(byte_read_finish), 0);
      check("reset_err", int'(byte_read_err), 0);
      rst_n = 1'b1;

      // Disabled: bus activity incl. SDA moves under SCL high does nothing
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); scl_i = 1'b0; sda_i = i[0];
         wait_clks(1);
         @(negedge clk); scl_i = 1'b1;
         @(negedge clk); sda_i = ~sda_i;
      end
      wait_clks(2);
      check("idle_byte", int'(byte_read_o), 0);

      // Normal bytes, SCL period 4 clk
      send_byte(8'h13, 2, 1'b1);
      send_byte(8'h57, 2, 1'b1);
      send_byte(8'h9B, 2, 1'b1);
      send_byte(8'hDF, 2, 1'b1);

      // Violation after 3 bits of 0xA5 (1,0,1)
      @(negedge clk); scl_i = 1'b0; byte_read_en = 1'b1; sda_i = 1'b1;
      wait_clks(1);
      @(negedge clk); scl_i = 1'b1; wait_clks(1);
      @(negedge clk); scl_i = 1'b0; sda_i = 1'b0; wait_clks(1);
      @(negedge clk); scl_i = 1'b1; wait_clks(1);
      @(negedge clk); scl_i = 1'b0; sda_i = 1'b1; wait_clks(1);
      @(negedge clk); scl_i = 1'b1;
      @(negedge clk); sda_i = 1'b0; push(1'b1, 8'hDF);
      @(negedge clk); scl_i = 1'b0; byte_read_en = 1'b0;
      wait_clks(2);
      send_byte(8'h3C, 2, 1'b1);

      // Abort after 5 bits of 0xFF
      @(negedge clk); scl_i = 1'b0; byte_read_en = 1'b1; sda_i = 1'b1;
      wait_clks(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); scl_i = 1'b1; wait_clks(1);
         @(negedge clk); scl_i = 1'b0; wait_clks(1);
      end
      @(negedge clk); byte_read_en = 1'b0;
      wait_clks(2);
      check("abort_byte", int'(byte_read_o), 8'h3C);
      send_byte(8'h81, 2, 1'b1);

      // Hold in DONE: enable stays high for 3 more SCL periods
      send_byte(8'h55, 2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); scl_i = 1'b1;
         @(negedge clk); sda_i = ~sda_i;
         @(negedge clk); scl_i = 1'b0; sda_i = ~sda_i;
         wait_clks(1);
      end
      @(negedge clk); byte_read_en = 1'b0;
      wait_clks(2);
      check("done_hold_byte", int'(byte_read_o), 8'h55);

      // Slow SCL, 10 clk period
      send_byte(8'h00, 5, 1'b1);
      send_byte(8'hFF, 5, 1'b1);

      wait_clks(10);
      check("all_pulses_seen", exp_q.size(), 0);
      check("final_byte", int'(byte_read_o), 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
